// File: rtl/tb_timer8_pkg.sv
// Shared register map, control-bit positions and prescaler divide
// encodings for the 8-bit APB timer.
package tb_timer8_pkg;

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;

    localparam int TCR_LOAD = 7;
    localparam int TCR_DW   = 5;
    localparam int TCR_EN   = 4;
    localparam int TCR_SEL_HI = 1;
    localparam int TCR_SEL_LO = 0;

    // Bits 6 and 3:2 do not exist in the control register.
    localparam logic [7:0] TCR_MASK = 8'hB3;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    typedef enum logic [1:0] {
        DIV2  = 2'b00,
        DIV4  = 2'b01,
        DIV8  = 2'b10,
        DIV16 = 2'b11
    } clk_sel_t;

    function automatic logic [3:0] div_last(input clk_sel_t sel);
        logic [3:0] last;
        unique case (sel)
            DIV2:    last = 4'd1;
            DIV4:    last = 4'd3;
            DIV8:    last = 4'd7;
            default: last = 4'd15;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/tb_timer8_prescaler.sv
// Divides pclk by 2/4/8/16 into a one-cycle count tick.
// First tick lands exactly N cycles after the enable edge.
module tb_timer8_prescaler
    import tb_timer8_pkg::*;
(
    input  logic       pclk,
    input  logic       presetn,
    input  logic [1:0] clk_sel,
    input  logic       en,
    input  logic       clr,
    output logic       tick
);

    logic [3:0] cnt;
    logic [3:0] last;

    assign last = div_last(clk_sel_t'(clk_sel));
    assign tick = en && !clr && (cnt == last);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt <= 4'd0;
        end else if (!en || clr) begin
            cnt <= 4'd0;
        end else if (cnt == last) begin
            cnt <= 4'd0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/tb_timer8.sv
// 8-bit up/down timer with zero-wait-state APB register access
// and sticky overflow/underflow flags driven out as interrupts.
module tb_timer8
    import tb_timer8_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              tmr_ovf,
    output logic              tmr_udf
);

    logic [7:0] tdr;
    logic [7:0] tcr;
    logic [1:0] tsr;
    logic [7:0] tcnt;

    logic acc, wr_en, rd_en;
    logic hit_tdr, hit_tcr, hit_tsr, hit_tcnt, mapped;
    logic load, dw, en, sel_chg, clr, tick;
    logic ovf_set, udf_set;
    logic [1:0] tsr_keep;

    assign acc      = psel & penable;
    assign wr_en    = acc & pwrite;
    assign rd_en    = acc & ~pwrite;
    assign hit_tdr  = (paddr == ADDR_W'(ADDR_TDR));
    assign hit_tcr  = (paddr == ADDR_W'(ADDR_TCR));
    assign hit_tsr  = (paddr == ADDR_W'(ADDR_TSR));
    assign hit_tcnt = (paddr == ADDR_W'(ADDR_TCNT));
    assign mapped   = hit_tdr | hit_tcr | hit_tsr | hit_tcnt;

    assign pready  = 1'b1;
    assign pslverr = acc & ~mapped;

    assign load = tcr[TCR_LOAD];
    assign dw   = tcr[TCR_DW];
    assign en   = tcr[TCR_EN];

    // A new divider selection restarts the prescaler from zero.
    assign sel_chg = wr_en & hit_tcr
                   & (pwdata[TCR_SEL_HI:TCR_SEL_LO] != tcr[TCR_SEL_HI:TCR_SEL_LO]);
    assign clr = load | sel_chg;

    tb_timer8_prescaler u_presc (
        .pclk    (pclk),
        .presetn (presetn),
        .clk_sel (tcr[TCR_SEL_HI:TCR_SEL_LO]),
        .en      (en),
        .clr     (clr),
        .tick    (tick)
    );

    assign ovf_set = tick & ~dw & (tcnt == 8'hFF);
    assign udf_set = tick &  dw & (tcnt == 8'h00);

    // Written zeros clear flags; a same-cycle hardware set still wins.
    assign tsr_keep = (wr_en & hit_tsr) ? (tsr & pwdata[1:0]) : tsr;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr  <= 8'h00;
            tcr  <= 8'h00;
            tsr  <= 2'b00;
            tcnt <= 8'h00;
        end else begin
            if (wr_en & hit_tdr) tdr <= pwdata;
            if (wr_en & hit_tcr) tcr <= pwdata & TCR_MASK;
            tsr[TSR_OVF] <= tsr_keep[TSR_OVF] | ovf_set;
            tsr[TSR_UDF] <= tsr_keep[TSR_UDF] | udf_set;
            if (load) begin
                tcnt <= tdr;
            end else if (tick) begin
                tcnt <= dw ? tcnt - 8'd1 : tcnt + 8'd1;
            end
        end
    end

    assign tmr_ovf = tsr[TSR_OVF];
    assign tmr_udf = tsr[TSR_UDF];

    always_comb begin
        prdata = '0;
        if (rd_en) begin
            unique case (1'b1)
                hit_tdr:  prdata = tdr;
                hit_tcr:  prdata = tcr;
                hit_tsr:  prdata = {6'b0, tsr};
                hit_tcnt: prdata = tcnt;
                default:  prdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_tb_timer8.sv
// Self-checking bench for tb_timer8: bus vector table, overflow and
// underflow timing, flag priority, reset, and randomized model runs.
module tb_tb_timer8;
    import tb_timer8_pkg::*;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] paddr = 8'h00;
    logic [7:0] pwdata = 8'h00;
    logic [7:0] prdata;
    logic       pready, pslverr, tmr_ovf, tmr_udf;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    tb_timer8 dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .tmr_ovf (tmr_ovf),
        .tmr_udf (tmr_udf)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic bus(input logic wr, input logic [7:0] a,
                       input logic [7:0] d, output logic [7:0] rd,
                       output logic err);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        rd = prdata;
        err = pslverr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        logic e;
        bus(1'b1, a, d, r, e);
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] d);
        logic e;
        bus(1'b0, a, 8'h00, d, e);
    endtask

    task automatic wait_to(input int t);
        if (cyc > t) begin
            n_cmp++;
            n_bad++;
            $display("FAIL schedule: got cycle %0d want <= %0d", cyc, t);
        end
        while (cyc < t) @(negedge pclk);
    endtask

    // Read sampled with state reflecting exactly t clock edges.
    task automatic read_at(input int t, input logic [7:0] a,
                           output logic [7:0] d);
        wait_to(t - 2);
        rd_reg(a, d);
    endtask

    task automatic start(input int v, input int dw, input int sel,
                         output int base);
        logic [7:0] c;
        c = 8'h10 | (dw != 0 ? 8'h20 : 8'h00) | 8'(sel);
        wr_reg(ADDR_TCR, 8'h00);
        wr_reg(ADDR_TSR, 8'h00);
        wr_reg(ADDR_TDR, 8'(v));
        wr_reg(ADDR_TCR, 8'h80);
        wr_reg(ADDR_TCR, c);
        base = cyc;
    endtask

    // Ideal timer: one tick every n cycles after enable.
    function automatic void model(input int v, input int dw, input int n,
                                  input int l, output int cnt,
                                  output int tsr);
        int t;
        t = l / n;
        if (dw == 0) begin
            cnt = (v + t) % 256;
            tsr = (v + t >= 256) ? 1 : 0;
        end else begin
            cnt = (((v - t) % 256) + 256) % 256;
            tsr = (t > v) ? 2 : 0;
        end
    endfunction

    initial begin
        logic [7:0] r;
        logic e;
        int base, n, sel, v, dw, l, ecnt, etsr;

        vt[0]  = '{1'b1, ADDR_TDR,  8'hA5, 8'h00, 1'b0};
        vt[1]  = '{1'b0, ADDR_TDR,  8'h00, 8'hA5, 1'b0};
        vt[2]  = '{1'b1, ADDR_TCR,  8'hFF, 8'h00, 1'b0};
        vt[3]  = '{1'b0, ADDR_TCR,  8'h00, 8'hB3, 1'b0};
        vt[4]  = '{1'b1, ADDR_TCR,  8'h4C, 8'h00, 1'b0};
        vt[5]  = '{1'b0, ADDR_TCR,  8'h00, 8'h00, 1'b0};
        vt[6]  = '{1'b0, ADDR_TCNT, 8'h00, 8'hA5, 1'b0};
        vt[7]  = '{1'b1, ADDR_TCNT, 8'h12, 8'h00, 1'b0};
        vt[8]  = '{1'b0, ADDR_TCNT, 8'h00, 8'hA5, 1'b0};
        vt[9]  = '{1'b1, 8'h10,     8'h55, 8'h00, 1'b1};
        vt[10] = '{1'b0, 8'h10,     8'h00, 8'h00, 1'b1};
        vt[11] = '{1'b0, ADDR_TDR,  8'h00, 8'hA5, 1'b0};
        vt[12] = '{1'b0, ADDR_TSR,  8'h00, 8'h00, 1'b0};
        vt[13] = '{1'b0, 8'h04,     8'h00, 8'h00, 1'b1};

        repeat (3) @(negedge pclk);
        check("rst ovf", tmr_ovf, 0);
        check("rst udf", tmr_udf, 0);
        check("rst prdata", prdata, 0);
        check("rst pslverr", pslverr, 0);
        presetn = 1'b1;
        @(negedge pclk);
        check("pready", pready, 1);

        for (int i = 0; i < 14; i++) begin
            bus(vt[i].wr, vt[i].addr, vt[i].wdata, r, e);
            check($sformatf("vec%0d rdata", i), r, vt[i].exp_rd);
            check($sformatf("vec%0d pslverr", i), e, vt[i].exp_err);
        end

        for (int i = 0; i < 20; i++) begin
            sel = (i < 4) ? i : int'($urandom_range(0, 3));
            n = 2 << sel;
            start(0, 0, sel, base);
            model(0, 0, n, 220 * n, ecnt, etsr);
            read_at(base + 220 * n, ADDR_TSR, r);
            check($sformatf("ovf%0d tsr@220N", i), r, etsr);
            wait_to(base + 256 * n - 1);
            model(0, 0, n, 256 * n - 1, ecnt, etsr);
            check($sformatf("ovf%0d line@256N-1", i), tmr_ovf, etsr);
            wait_to(base + 256 * n);
            model(0, 0, n, 256 * n, ecnt, etsr);
            check($sformatf("ovf%0d line@256N", i), tmr_ovf, etsr);
            read_at(base + 256 * n + 2, ADDR_TSR, r);
            check($sformatf("ovf%0d tsr@256N", i), r, 8'h01);
            wr_reg(ADDR_TSR, 8'h00);
            rd_reg(ADDR_TSR, r);
            check($sformatf("ovf%0d tsr clr", i), r, 8'h00);
        end

        start(5, 1, 1, base);
        wait_to(base + 23);
        check("udf line@23", tmr_udf, 0);
        wait_to(base + 24);
        check("udf line@24", tmr_udf, 1);
        read_at(base + 26, ADDR_TCNT, r);
        check("udf tcnt", r, 8'hFF);
        read_at(base + 29, ADDR_TSR, r);
        check("udf tsr", r, 8'h02);

        start(8'hF0, 0, 0, base);
        wait_to(base + 30);
        check("preset ovf@30", tmr_ovf, 0);
        wait_to(base + 31);
        check("preset ovf@31", tmr_ovf, 0);
        wait_to(base + 32);
        check("preset ovf@32", tmr_ovf, 1);

        start(8'hF0, 0, 0, base);
        wait_to(base + 29);
        wr_reg(ADDR_TSR, 8'h00);
        check("prio cycle", cyc, base + 32);
        rd_reg(ADDR_TSR, r);
        check("prio set wins", r, 8'h01);
        wr_reg(ADDR_TSR, 8'hFF);
        rd_reg(ADDR_TSR, r);
        check("prio ff keeps", r, 8'h01);

        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(0, 255));
            dw = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 3));
            l = int'($urandom_range(10, 600));
            n = 2 << sel;
            start(v, dw, sel, base);
            model(v, dw, n, l, ecnt, etsr);
            read_at(base + l, ADDR_TCNT, r);
            check($sformatf("rnd%0d tcnt", i), r, ecnt);
            model(v, dw, n, l + 3, ecnt, etsr);
            read_at(base + l + 3, ADDR_TSR, r);
            check($sformatf("rnd%0d tsr", i), r, etsr);
        end

        start(8'hFE, 0, 0, base);
        wait_to(base + 10);
        presetn = 1'b0;
        #1;
        check("mid rst ovf", tmr_ovf, 0);
        check("mid rst udf", tmr_udf, 0);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
        for (int a = 0; a < 4; a++) begin
            paddr = 8'(a);
            #1;
            check($sformatf("mid rst rd%0d", a), prdata, 0);
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd_reg(8'(a), r);
            check($sformatf("post rst rd%0d", a), r, 0);
        end
        @(negedge pclk);
        check("post rst prdata idle", prdata, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
